// File: rtl/alp_seq_if.sv
// Handshake and control bundle between the microsequencer, the ALP sequencer and the datapath slice.
`default_nettype none

interface alp_seq_if #(
  parameter int OPC_W = 10,
  parameter int CNT_W = 5
);
  logic             uinst_valid_h;
  logic [OPC_W-1:0] opc_in_h;
  logic [CNT_W-1:0] steps_in_h;
  logic             stall_h;
  logic             ready_h;
  logic             busy_h;
  logic [OPC_W-1:0] opc_h;
  logic [CNT_W-1:0] step_h;
  logic             done_h;
  logic             dmove_h;
  logic             dreg_ld_h;
  logic             pass_a_h;
  logic             wmux_oe_h;

  modport master (
    output uinst_valid_h, opc_in_h, steps_in_h, stall_h,
    input  ready_h, busy_h, opc_h, step_h, done_h,
    input  dmove_h, dreg_ld_h, pass_a_h, wmux_oe_h
  );

  modport slave (
    input  uinst_valid_h, opc_in_h, steps_in_h, stall_h,
    output ready_h, busy_h, opc_h, step_h, done_h,
    output dmove_h, dreg_ld_h, pass_a_h, wmux_oe_h
  );
endinterface

`default_nettype wire

// File: rtl/alp_seq.sv
// ALP micro-cycle sequencer: holds an ALPCTL opcode for single or iterative execution
// and drives the slice's per-cycle controls, honouring datapath stall.
`default_nettype none

module alp_seq #(
  parameter int OPC_W = 10,
  parameter int CNT_W = 5
) (
  input  wire logic  clk_h,
  input  wire logic  reset_l,
  alp_seq_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [OPC_W-1:0] opc_q;
  logic [CNT_W-1:0] cnt;

  logic busy;
  logic last;
  logic ready;
  logic accept;
  logic dmove;
  logic inh;
  logic pass_a;
  logic wmux;

  assign busy   = (state == RUN);
  // Final execute cycle: frees the slot so a new opcode can follow with no bubble.
  assign last   = busy & ~bus.stall_h & (cnt == '0);
  assign ready  = ~busy | last;
  assign accept = bus.uinst_valid_h & ready;

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
      opc_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= RUN;
      opc_q <= bus.opc_in_h;
      cnt   <= bus.steps_in_h;
    end else if (last) begin
      state <= IDLE;
    end else if (busy && !bus.stall_h) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Opcode field decode for the slice controls.
  assign dmove  = ({opc_q[6], opc_q[5], opc_q[3:0]} == 6'b10_0111);
  assign inh    = dmove & ~opc_q[4] & (opc_q[1:0] == 2'b11);
  assign pass_a = ({opc_q[9:6], opc_q[3], opc_q[1]} == 6'b1001_1_1);
  assign wmux   = ~({opc_q[9], opc_q[7:5]} == 4'b1011);

  assign bus.ready_h   = ready;
  assign bus.busy_h    = busy;
  assign bus.opc_h     = opc_q;
  assign bus.step_h    = cnt;
  assign bus.done_h    = last;
  assign bus.dmove_h   = busy & dmove;
  assign bus.pass_a_h  = busy & pass_a;
  assign bus.wmux_oe_h = busy & wmux;
  assign bus.dreg_ld_h = busy & ~bus.stall_h & ~inh;

endmodule

`default_nettype wire

// File: tb/tb_alp_seq.sv
// Self-checking bench for alp_seq: directed vector table, multi-cycle sequences, random vs model.
`default_nettype none

module tb_alp_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alp_seq_if #(.OPC_W(10), .CNT_W(5)) bus ();

  alp_seq #(.OPC_W(10), .CNT_W(5)) dut (
    .clk_h   (clk),
    .reset_l (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        v;
    logic [9:0]  opc;
    logic [4:0]  steps;
    logic        stall;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [21:0] pack(logic r, logic b, logic d, logic dm, logic dr,
                                       logic pa, logic wm, logic [4:0] stp, logic [9:0] op);
    return {r, b, d, dm, dr, pa, wm, stp, op};
  endfunction

  function automatic logic [21:0] got();
    return pack(bus.ready_h, bus.busy_h, bus.done_h, bus.dmove_h, bus.dreg_ld_h,
                bus.pass_a_h, bus.wmux_oe_h, bus.step_h, bus.opc_h);
  endfunction

  task automatic add(logic v, logic [9:0] opc, logic [4:0] steps, logic stall,
                     logic r, logic b, logic d, logic dm, logic dr, logic pa, logic wm,
                     logic [4:0] stp, logic [9:0] op);
    vec_t e;
    e.v = v; e.opc = opc; e.steps = steps; e.stall = stall;
    e.exp = pack(r, b, d, dm, dr, pa, wm, stp, op);
    tbl.push_back(e);
  endtask

  task automatic check(string name, logic [31:0] actual, logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, actual, required);
    end
  endtask

  // Drive inputs away from the rising edge, then let them settle before sampling.
  task automatic drive(logic v, logic [9:0] opc, logic [4:0] steps, logic stall);
    @(negedge clk);
    bus.uinst_valid_h = v;
    bus.opc_in_h      = opc;
    bus.steps_in_h    = steps;
    bus.stall_h       = stall;
    #2;
  endtask

  // Reference model: a held job with a count of remaining extra iterations.
  logic       m_busy;
  logic [9:0] m_opc;
  int         m_rem;

  function automatic logic [21:0] model_out(logic stall);
    logic dm, pa, wm, inh, fin;
    dm  = m_opc[6] && !m_opc[5] && (m_opc[3:0] == 4'd7);
    inh = dm && !m_opc[4];
    pa  = (m_opc[9:6] == 4'd9) && m_opc[3] && m_opc[1];
    wm  = !(m_opc[9] && (m_opc[7:5] == 3'd3));
    fin = m_busy && !stall && (m_rem == 0);
    return pack(!m_busy || fin, m_busy, fin, m_busy && dm, m_busy && !stall && !inh,
                m_busy && pa, m_busy && wm, 5'(m_rem), m_opc);
  endfunction

  task automatic model_step(logic v, logic [9:0] opc, logic [4:0] steps, logic stall);
    logic fin;
    fin = m_busy && !stall && (m_rem == 0);
    if (v && (!m_busy || fin)) begin
      m_busy = 1'b1; m_opc = opc; m_rem = int'(steps);
    end else if (fin) begin
      m_busy = 1'b0;
    end else if (m_busy && !stall) begin
      m_rem = m_rem - 1;
    end
  endtask

  initial begin
    int n_exec, n_done;
    logic [4:0] last_step;

    bus.uinst_valid_h = 1'b0;
    bus.opc_in_h      = '0;
    bus.steps_in_h    = '0;
    bus.stall_h       = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("reset_state", 32'(got()), 32'(pack(1,0,0,0,0,0,0,5'd0,10'h000)));
    @(negedge clk);
    rst_n = 1'b1;

    // v opc steps stall | ready busy done dmove dreg pass wmux step opc
    add(1,10'h047,0,0, 1,0,0,0,0,0,0, 0,10'h000);
    add(0,10'h000,0,0, 1,1,1,1,0,0,1, 0,10'h047);
    add(1,10'h057,0,0, 1,0,0,0,0,0,0, 0,10'h047);
    add(0,10'h000,0,0, 1,1,1,1,1,0,1, 0,10'h057);
    add(1,10'h24A,3,0, 1,0,0,0,0,0,0, 0,10'h057);
    add(0,10'h000,0,0, 0,1,0,0,1,1,1, 3,10'h24A);
    add(0,10'h000,0,1, 0,1,0,0,0,1,1, 2,10'h24A);
    add(0,10'h000,0,1, 0,1,0,0,0,1,1, 2,10'h24A);
    add(0,10'h000,0,0, 0,1,0,0,1,1,1, 2,10'h24A);
    add(0,10'h000,0,0, 0,1,0,0,1,1,1, 1,10'h24A);
    add(0,10'h000,0,0, 1,1,1,0,1,1,1, 0,10'h24A);
    add(1,10'h24A,0,0, 1,0,0,0,0,0,0, 0,10'h24A);
    add(1,10'h260,0,0, 1,1,1,0,1,1,1, 0,10'h24A);
    add(0,10'h000,0,0, 1,1,1,0,1,0,0, 0,10'h260);
    add(0,10'h000,0,0, 1,0,0,0,0,0,0, 0,10'h260);
    add(1,10'h24A,2,0, 1,0,0,0,0,0,0, 0,10'h260);
    add(1,10'h057,0,0, 0,1,0,0,1,1,1, 2,10'h24A);
    add(1,10'h057,0,1, 0,1,0,0,0,1,1, 1,10'h24A);
    add(1,10'h057,0,0, 0,1,0,0,1,1,1, 1,10'h24A);
    add(1,10'h057,0,1, 0,1,0,0,0,1,1, 0,10'h24A);
    add(1,10'h057,0,0, 1,1,1,0,1,1,1, 0,10'h24A);
    add(0,10'h000,0,0, 1,1,1,1,1,0,1, 0,10'h057);
    add(0,10'h000,0,1, 1,0,0,0,0,0,0, 0,10'h057);
    add(1,10'h047,0,1, 1,0,0,0,0,0,0, 0,10'h057);
    add(0,10'h000,0,0, 1,1,1,1,0,0,1, 0,10'h047);
    add(0,10'h000,0,0, 1,0,0,0,0,0,0, 0,10'h047);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].opc, tbl[i].steps, tbl[i].stall);
      check($sformatf("table[%0d]", i), 32'(got()), 32'(tbl[i].exp));
    end

    // Full-range iteration count: 32 execute cycles, no wrap, one done.
    drive(1, 10'h24A, 5'd31, 0);
    n_exec = 0; n_done = 0; last_step = '1;
    for (int c = 0; c < 40; c++) begin
      drive(0, 10'h000, 0, 0);
      if (bus.busy_h) begin
        check($sformatf("max_step[%0d]", n_exec), 32'(bus.step_h), 32'(31 - n_exec));
        last_step = bus.step_h;
        n_exec++;
      end
      if (bus.done_h) n_done++;
    end
    check("max_exec_cycles", 32'(n_exec), 32'd32);
    check("max_done_count", 32'(n_done), 32'd1);
    check("max_final_step", 32'(last_step), 32'd0);

    // Asynchronous reset in the middle of an iterative opcode.
    drive(1, 10'h047, 5'd5, 0);
    drive(0, 10'h000, 0, 0);
    drive(0, 10'h000, 0, 0);
    check("pre_reset_busy", 32'(bus.busy_h), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_run", 32'(got()), 32'(pack(1,0,0,0,0,0,0,5'd0,10'h000)));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(0, 10'h000, 0, 0);
      check($sformatf("post_reset_idle[%0d]", c), 32'(got()),
            32'(pack(1,0,0,0,0,0,0,5'd0,10'h000)));
    end

    // Random traffic against the reference model.
    m_busy = 1'b0; m_opc = '0; m_rem = 0;
    for (int c = 0; c < 400; c++) begin
      logic v, st;
      logic [9:0] op;
      logic [4:0] sp;
      v  = ($urandom_range(0, 1) == 1);
      st = ($urandom_range(0, 3) == 0);
      op = 10'($urandom);
      sp = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      drive(v, op, sp, st);
      check($sformatf("random[%0d]", c), 32'(got()), 32'(model_out(st)));
      model_step(v, op, sp, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alp_seq.md
Name: alp_seq

Overview:
- Micro-cycle sequencer for the ALP datapath slice.
- Accepts a 10-bit ALPCTL opcode from the microsequencer and holds it for single-cycle or iterative (multi-step) execution, honouring a datapath stall.
- Drives the slice's per-cycle controls: data-move, D-register load, A-pass and W-mux output enable.
- Gives upstream a ready/accept handshake and a completion strobe.

Parameters:
- OPC_W, 10, ALPCTL opcode width.
- CNT_W, 5, iteration counter width; max steps = 2^CNT_W.

Ports:
- clk_h  in  1  system clock, rising edge.
- reset_l  in  1  asynchronous reset, active low.
- uinst_valid_h  in  1  new ALPCTL opcode presented.
- opc_in_h  in  OPC_W  opcode to execute.
- steps_in_h  in  CNT_W  extra iterations (0 = single cycle).
- stall_h  in  1  datapath stall; freezes sequencing.
- ready_h  out  1  block will accept opc_in_h this cycle.
- busy_h  out  1  an opcode is executing.
- opc_h  out  OPC_W  currently held opcode.
- step_h  out  CNT_W  remaining iterations.
- done_h  out  1  final, non-stalled execute cycle.
- dmove_h  out  1  data-move decode, gated.
- dreg_ld_h  out  1  D register load enable.
- pass_a_h  out  1  ALU bypass, gated.
- wmux_oe_h  out  1  W-mux drive enable, gated.

Behaviour:
- Reset (async on reset_l low, held until release):
  - state = IDLE; opc_q = 0; cnt = 0.
  - All outputs 0 except ready_h = 1.
  - Reset mid-operation aborts the operation; no done_h.
- States:
  - IDLE: ready_h = 1.
  - RUN: busy_h = 1.
- Accept = uinst_valid_h & ready_h.
  - On accept: opc_q <= opc_in_h; cnt <= steps_in_h; state <= RUN next edge.
  - uinst_valid_h without ready_h is ignored; upstream holds the opcode.
- In RUN:
  - stall_h = 1: opc_q, cnt and state frozen; done_h = 0; dreg_ld_h = 0.
  - stall_h = 0, cnt != 0: cnt decrements by 1.
  - stall_h = 0, cnt == 0: done_h = 1. Next state is RUN if an accept occurs this cycle, else IDLE.
- ready_h = (state == IDLE) | (RUN & ~stall_h & cnt == 0). This allows back-to-back opcodes with zero bubble.
- Decode (combinational on opc_q; all outputs gated by busy_h):
  - dmove = {opc[6],opc[5],opc[3:0]} == 6'b10_0111.
  - inh = dmove & opc[4] == 0 & opc[1:0] == 2'b11.
  - pass_a = {opc[9:6],opc[3],opc[1]} == 6'b1001_1_1.
  - wmux = ~({opc[9],opc[7:5]} == 4'b1011).
- Outputs:
  - dmove_h = busy & dmove.
  - pass_a_h = busy & pass_a.
  - wmux_oe_h = busy & wmux.
  - dreg_ld_h = busy & ~stall_h & ~inh.
- opc_h = opc_q; step_h = cnt; both hold their last values in IDLE until the next accept.
- Latency: opcode accepted at edge N is driving controls in cycle N+1. With no stalls, an opcode with steps = S occupies S+1 cycles.
- Counter never wraps. Loading steps_in_h = 2^CNT_W − 1 gives exactly 2^CNT_W execute cycles.
- stall_h in IDLE has no effect; an accept still occurs.

Test Plan:
- Reset then idle: reset_l low mid-RUN with opc 0x047 → all outputs 0 immediately, ready_h = 1; after release there is no done_h.
- Single data move: accept opc 0x047, steps 0 → next cycle busy_h = 1, dmove_h = 1, dreg_ld_h = 0 (inhibit), wmux_oe_h = 1, done_h = 1; following cycle busy_h = 0. Repeat with 0x057 → dreg_ld_h = 1.
- Iterative with stall: accept 0x24A, steps 3, stall_h high for 2 cycles after the first execute cycle:
  - pass_a_h = 1 for 6 cycles; step_h sequence 3,2,2,2,1,0.
  - done_h only in the sixth cycle; dreg_ld_h = 0 during the stall cycles.
- Back-to-back: 0x24A (steps 0) then 0x260 (steps 0) with uinst_valid_h continuous → no idle bubble; wmux_oe_h = 1 then 0; two done_h pulses in consecutive cycles.
- Blocked request: during RUN with steps 2, uinst_valid_h = 1 with opc 0x057 → ignored until cnt = 0 and stall_h = 0; accepted on that cycle; opc_h changes the next cycle.
- Max count: steps_in_h = 31 → exactly 32 execute cycles, step_h ends at 0, no wrap, single done_h.
